// File: rtl/axil_mem_arbiter.sv
// rtl/axil_mem_arbiter.sv - two-master to one-slave AXI-lite arbiter for a shared memory wrapper
//
// Purpose: shares one memory wrapper between the instruction-fetch master (m0)
// and the data master (m1). One complete read or write transaction is granted
// at a time. The granted master's channels are passed straight through to the
// slave with no added latency.
//
// Ports:
//   clk, reset          - rising-edge clock; asynchronous active-low reset
//   m0_*, m1_*          - slave-side AXI-lite ports (AW, W, B, AR, R) facing the core
//   s_*                 - master-side AXI-lite port facing the memory wrapper
//   grant               - index of the master owning the slave, valid while busy
//   busy                - high while a transaction is in flight (state != IDLE)
//
// Configuration macro:
//   AXIL_ARB_FIXED_PRIO_EN - when defined, m1 always wins a tie (fixed priority);
//                            otherwise ties are resolved round-robin.

module axil_mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  // master 0 (instruction fetch)
  input  logic                m0_awvalid,
  output logic                m0_awready,
  input  logic [ADDR_W-1:0]   m0_awaddr,
  input  logic [2:0]          m0_awprot,
  input  logic                m0_wvalid,
  output logic                m0_wready,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic                m0_bvalid,
  input  logic                m0_bready,
  output logic                m0_bresp,
  input  logic                m0_arvalid,
  output logic                m0_arready,
  input  logic [ADDR_W-1:0]   m0_araddr,
  input  logic [2:0]          m0_arprot,
  output logic                m0_rvalid,
  input  logic                m0_rready,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_rresp,
  // master 1 (data)
  input  logic                m1_awvalid,
  output logic                m1_awready,
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic [2:0]          m1_awprot,
  input  logic                m1_wvalid,
  output logic                m1_wready,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_bvalid,
  input  logic                m1_bready,
  output logic                m1_bresp,
  input  logic                m1_arvalid,
  output logic                m1_arready,
  input  logic [ADDR_W-1:0]   m1_araddr,
  input  logic [2:0]          m1_arprot,
  output logic                m1_rvalid,
  input  logic                m1_rready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_rresp,
  // shared slave (memory wrapper)
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic [2:0]          s_awprot,
  output logic                s_wvalid,
  input  logic                s_wready,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_bvalid,
  output logic                s_bready,
  input  logic                s_bresp,
  output logic                s_arvalid,
  input  logic                s_arready,
  output logic [ADDR_W-1:0]   s_araddr,
  output logic [2:0]          s_arprot,
  input  logic                s_rvalid,
  output logic                s_rready,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic                s_rresp,
  // status
  output logic                grant,
  output logic                busy
);

  typedef enum logic [2:0] {IDLE, WR, WB, RD_A, RD_R} state_t;

  state_t state, state_nxt;
  logic   grant_nxt;
  logic   aw_done, w_done, aw_done_nxt, w_done_nxt;

  logic   req0, req1, pick, pick_aw;

  // handshake signals of the currently granted master
  logic   g_awvalid, g_wvalid, g_bready, g_arvalid, g_rready;
  logic   g_awready, g_wready, g_bvalid, g_arready, g_rvalid;

  assign req0 = m0_awvalid | m0_arvalid;
  assign req1 = m1_awvalid | m1_arvalid;

`ifdef AXIL_ARB_FIXED_PRIO_EN
  assign pick = req1;
`else
  logic last_grant;
  // on a tie the master not granted last time wins; otherwise the sole requester
  assign pick = (req0 & req1) ? ~last_grant : req1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= 1'b1;
    end else if (state == IDLE && (req0 | req1)) begin
      last_grant <= pick;
    end
  end
`endif

  // a pending write is served before a pending read of the same master
  assign pick_aw = pick ? m1_awvalid : m0_awvalid;

  assign g_awvalid = grant ? m1_awvalid : m0_awvalid;
  assign g_wvalid  = grant ? m1_wvalid  : m0_wvalid;
  assign g_bready  = grant ? m1_bready  : m0_bready;
  assign g_arvalid = grant ? m1_arvalid : m0_arvalid;
  assign g_rready  = grant ? m1_rready  : m0_rready;

  // payloads are don't-care outside the active channel, so they follow grant freely
  assign s_awaddr = grant ? m1_awaddr : m0_awaddr;
  assign s_awprot = grant ? m1_awprot : m0_awprot;
  assign s_wdata  = grant ? m1_wdata  : m0_wdata;
  assign s_wstrb  = grant ? m1_wstrb  : m0_wstrb;
  assign s_araddr = grant ? m1_araddr : m0_araddr;
  assign s_arprot = grant ? m1_arprot : m0_arprot;

  assign m0_bresp = s_bresp;
  assign m1_bresp = s_bresp;
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;
  assign m0_rresp = s_rresp;
  assign m1_rresp = s_rresp;

  assign m0_awready = g_awready & ~grant;
  assign m1_awready = g_awready &  grant;
  assign m0_wready  = g_wready  & ~grant;
  assign m1_wready  = g_wready  &  grant;
  assign m0_bvalid  = g_bvalid  & ~grant;
  assign m1_bvalid  = g_bvalid  &  grant;
  assign m0_arready = g_arready & ~grant;
  assign m1_arready = g_arready &  grant;
  assign m0_rvalid  = g_rvalid  & ~grant;
  assign m1_rvalid  = g_rvalid  &  grant;

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;
    s_awvalid   = 1'b0;
    s_wvalid    = 1'b0;
    s_bready    = 1'b0;
    s_arvalid   = 1'b0;
    s_rready    = 1'b0;
    g_awready   = 1'b0;
    g_wready    = 1'b0;
    g_bvalid    = 1'b0;
    g_arready   = 1'b0;
    g_rvalid    = 1'b0;
    case (state)
      IDLE: begin
        if (req0 | req1) begin
          grant_nxt = pick;
          state_nxt = pick_aw ? WR : RD_A;
        end
      end
      WR: begin
        // AW and W complete independently; a finished channel is masked off
        s_awvalid   = g_awvalid & ~aw_done;
        g_awready   = s_awready & ~aw_done;
        s_wvalid    = g_wvalid  & ~w_done;
        g_wready    = s_wready  & ~w_done;
        aw_done_nxt = aw_done | (s_awvalid & s_awready);
        w_done_nxt  = w_done  | (s_wvalid  & s_wready);
        if (aw_done_nxt && w_done_nxt) begin
          state_nxt = WB;
        end
      end
      WB: begin
        s_bready = g_bready;
        g_bvalid = s_bvalid;
        if (s_bvalid && g_bready) begin
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
          state_nxt   = IDLE;
        end
      end
      RD_A: begin
        s_arvalid = g_arvalid;
        g_arready = s_arready;
        if (g_arvalid && s_arready) begin
          state_nxt = RD_R;
        end
      end
      RD_R: begin
        s_rready = g_rready;
        g_rvalid = s_rvalid;
        if (s_rvalid && g_rready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      grant   <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_axil_mem_arbiter.sv
// tb/tb_axil_mem_arbiter.sv - directed self-checking bench for axil_mem_arbiter

module tb_axil_mem_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

`ifdef AXIL_ARB_FIXED_PRIO_EN
  localparam logic [3:0] TIE_ORDER = 4'b1111;
  localparam logic       TIE_FIRST = 1'b1;
`else
  localparam logic [3:0] TIE_ORDER = 4'b1010;
  localparam logic       TIE_FIRST = 1'b0;
`endif

  logic clk, reset;

  logic                m0_awvalid, m0_awready, m0_wvalid, m0_wready, m0_bvalid, m0_bready, m0_bresp;
  logic                m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rresp;
  logic [ADDR_W-1:0]   m0_awaddr, m0_araddr;
  logic [2:0]          m0_awprot, m0_arprot;
  logic [DATA_W-1:0]   m0_wdata, m0_rdata;
  logic [DATA_W/8-1:0] m0_wstrb;

  logic                m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready, m1_bresp;
  logic                m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_rresp;
  logic [ADDR_W-1:0]   m1_awaddr, m1_araddr;
  logic [2:0]          m1_awprot, m1_arprot;
  logic [DATA_W-1:0]   m1_wdata, m1_rdata;
  logic [DATA_W/8-1:0] m1_wstrb;

  logic                s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready, s_bresp;
  logic                s_arvalid, s_arready, s_rvalid, s_rready, s_rresp;
  logic [ADDR_W-1:0]   s_awaddr, s_araddr;
  logic [2:0]          s_awprot, s_arprot;
  logic [DATA_W-1:0]   s_wdata, s_rdata;
  logic [DATA_W/8-1:0] s_wstrb;

  logic grant, busy;

  int n_vec = 0;
  int n_err = 0;

  logic mon_en = 1'b0;
  int   busy_cnt = 0;
  int   b1_cnt = 0;
  int   m0_act = 0;

  logic [14:0] hs;
  assign hs = {m0_awready, m0_wready, m0_bvalid, m0_arready, m0_rvalid,
               m1_awready, m1_wready, m1_bvalid, m1_arready, m1_rvalid,
               s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready};

  axil_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .m0_awvalid(m0_awvalid), .m0_awready(m0_awready), .m0_awaddr(m0_awaddr), .m0_awprot(m0_awprot),
    .m0_wvalid(m0_wvalid), .m0_wready(m0_wready), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_bvalid(m0_bvalid), .m0_bready(m0_bready), .m0_bresp(m0_bresp),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr), .m0_arprot(m0_arprot),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
    .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr), .m1_awprot(m1_awprot),
    .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bresp(m1_bresp),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr), .m1_arprot(m1_arprot),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awprot(s_awprot),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .grant(grant), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      if (busy) busy_cnt++;
      if (m1_bvalid) b1_cnt++;
      if (m0_awready | m0_wready | m0_arready | m0_bvalid | m0_rvalid) m0_act++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    m0_awvalid = 0; m0_awaddr = '0; m0_awprot = '0; m0_wvalid = 0; m0_wdata = '0; m0_wstrb = '0;
    m0_bready = 0; m0_arvalid = 0; m0_araddr = '0; m0_arprot = '0; m0_rready = 0;
    m1_awvalid = 0; m1_awaddr = '0; m1_awprot = '0; m1_wvalid = 0; m1_wdata = '0; m1_wstrb = '0;
    m1_bready = 0; m1_arvalid = 0; m1_araddr = '0; m1_arprot = '0; m1_rready = 0;
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0; s_arready = 0;
    s_rvalid = 0; s_rdata = '0; s_rresp = 0;
  endtask

  logic [3:0] order;
  int         got_n;

  initial begin
    clr();
    reset = 1'b0;
    // readies/valids offered from outside while in reset must not leak through
    m0_arvalid = 1; m1_awvalid = 1; m0_rready = 1; m1_bready = 1;
    s_bvalid = 1; s_rvalid = 1; s_arready = 1; s_awready = 1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 0);
    check("rst_handshakes", hs, 0);
    @(negedge clk);
    clr();
    reset = 1'b1;

    // single read from m0
    @(negedge clk);
    m0_arvalid = 1; m0_araddr = 12'h010; m0_rready = 1;
    busy_cnt = 0; mon_en = 1;
    #1 check("t1_idle_busy", busy, 0);
    check("t1_idle_arvalid", s_arvalid, 0);
    @(negedge clk);
    #1 check("t1_grant", grant, 0);
    check("t1_s_arvalid", s_arvalid, 1);
    check("t1_s_araddr", s_araddr, 12'h010);
    s_arready = 1;
    #1 check("t1_m0_arready", m0_arready, 1);
    check("t1_m1_arready", m1_arready, 0);
    @(negedge clk);
    m0_arvalid = 0; s_arready = 0;
    #1 check("t1_rdr_arvalid", s_arvalid, 0);
    check("t1_rdr_norv", m0_rvalid, 0);
    @(negedge clk);
    s_rvalid = 1; s_rdata = 32'hDEADBEEF; s_rresp = 0;
    #1 check("t1_rvalid", m0_rvalid, 1);
    check("t1_rdata", m0_rdata, 32'hDEADBEEF);
    check("t1_rresp", m0_rresp, 0);
    check("t1_s_rready", s_rready, 1);
    check("t1_m1_rvalid", m1_rvalid, 0);
    @(negedge clk);
    s_rvalid = 0;
    #1 check("t1_done_busy", busy, 0);
    @(negedge clk);
    mon_en = 0;
    check("t1_busy_cycles", busy_cnt, 3);
    clr();

    // split write from m1
    @(negedge clk);
    m1_awvalid = 1; m1_awaddr = 12'h040; m1_bready = 1;
    s_awready = 1; s_wready = 1;
    b1_cnt = 0; mon_en = 1;
    @(negedge clk);
    #1 check("t2_grant", grant, 1);
    check("t2_s_awvalid", s_awvalid, 1);
    check("t2_s_awaddr", s_awaddr, 12'h040);
    check("t2_s_wvalid_idle", s_wvalid, 0);
    check("t2_m1_awready", m1_awready, 1);
    check("t2_m0_awready", m0_awready, 0);
    @(negedge clk);
    #1 check("t2_aw_masked", s_awvalid, 0);
    check("t2_awready_masked", m1_awready, 0);
    @(negedge clk);
    m1_awvalid = 0; m1_wvalid = 1; m1_wdata = 32'h12345678; m1_wstrb = 4'hF;
    #1 check("t2_s_wvalid", s_wvalid, 1);
    check("t2_s_wdata", s_wdata, 32'h12345678);
    check("t2_s_wstrb", s_wstrb, 4'hF);
    check("t2_m1_wready", m1_wready, 1);
    @(negedge clk);
    m1_wvalid = 0;
    #1 check("t2_wb_busy", busy, 1);
    check("t2_wb_wvalid", s_wvalid, 0);
    check("t2_wb_nobv", m1_bvalid, 0);
    check("t2_s_bready", s_bready, 1);
    @(negedge clk);
    s_bvalid = 1; s_bresp = 0;
    #1 check("t2_m1_bvalid", m1_bvalid, 1);
    check("t2_m0_bvalid", m0_bvalid, 0);
    @(negedge clk);
    s_bvalid = 0;
    #1 check("t2_done_busy", busy, 0);
    @(negedge clk);
    mon_en = 0;
    check("t2_bvalid_count", b1_cnt, 1);
    clr();

    // continuous tie between both masters, starting from reset
    reset = 0;
    @(negedge clk);
    reset = 1;
    m0_arvalid = 1; m1_arvalid = 1; m0_rready = 1; m1_rready = 1;
    s_arready = 1; s_rvalid = 1;
    got_n = 0;
    order = '0;
    for (int cyc = 0; cyc < 40 && got_n < 4; cyc++) begin
      @(negedge clk);
      #1;
      if (s_arvalid) begin
        order[got_n] = grant;
        got_n++;
      end
    end
    check("t3_grants_seen", got_n, 4);
    for (int i = 0; i < 4; i++) check($sformatf("t3_grant%0d", i), order[i], TIE_ORDER[i]);
    @(negedge clk);
    m0_arvalid = 0; m1_arvalid = 0;
    @(negedge clk);
    clr();
    #1 check("t3_drain", busy, 0);

    // m1 write and read together: write first, m0 untouched
    @(negedge clk);
    m1_awvalid = 1; m1_wvalid = 1; m1_arvalid = 1;
    m1_awaddr = 12'h100; m1_wdata = 32'h0000CAFE; m1_wstrb = 4'h3; m1_araddr = 12'h104;
    m1_bready = 1; m1_rready = 1;
    s_awready = 1; s_wready = 1; s_arready = 1;
    m0_act = 0; mon_en = 1;
    @(negedge clk);
    #1 check("t4_grant", grant, 1);
    check("t4_s_awvalid", s_awvalid, 1);
    check("t4_s_wvalid", s_wvalid, 1);
    check("t4_no_ar", s_arvalid, 0);
    check("t4_m1_arready", m1_arready, 0);
    @(negedge clk);
    m1_awvalid = 0; m1_wvalid = 0; s_bvalid = 1;
    #1 check("t4_b_first", m1_bvalid, 1);
    check("t4_no_r", m1_rvalid, 0);
    @(negedge clk);
    s_bvalid = 0;
    #1 check("t4_bubble", busy, 0);
    @(negedge clk);
    #1 check("t4_ar", s_arvalid, 1);
    check("t4_ar_addr", s_araddr, 12'h104);
    @(negedge clk);
    m1_arvalid = 0; s_rvalid = 1; s_rdata = 32'h0BADF00D;
    #1 check("t4_r", m1_rvalid, 1);
    check("t4_rdata", m1_rdata, 32'h0BADF00D);
    @(negedge clk);
    s_rvalid = 0;
    #1 check("t4_done", busy, 0);
    @(negedge clk);
    mon_en = 0;
    check("t4_m0_idle", m0_act, 0);
    clr();

    // R backpressure from m0 while m1 waits
    @(negedge clk);
    m0_arvalid = 1; m0_araddr = 12'h020; s_arready = 1;
    @(negedge clk);
    m1_arvalid = 1; m1_araddr = 12'h030;
    #1 check("t5_grant0", grant, 0);
    check("t5_ar", s_arvalid, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin
        m0_arvalid = 0; s_rvalid = 1; s_rdata = 32'hA5A5A5A5;
      end
      #1 check($sformatf("t5_rvalid%0d", i), m0_rvalid, 1);
      check($sformatf("t5_rdata%0d", i), m0_rdata, 32'hA5A5A5A5);
      check($sformatf("t5_rready%0d", i), s_rready, 0);
      check($sformatf("t5_hold%0d", i), {busy, grant, s_arvalid, m1_arready}, 4'b1000);
    end
    @(negedge clk);
    m0_rready = 1;
    #1 check("t5_release", s_rready, 1);
    @(negedge clk);
    s_rvalid = 0; m0_rready = 0;
    #1 check("t5_bubble", {busy, s_arvalid}, 2'b00);
    @(negedge clk);
    #1 check("t5_grant1", grant, 1);
    check("t5_m1_ar", s_arvalid, 1);
    check("t5_m1_araddr", s_araddr, 12'h030);
    @(negedge clk);
    m1_arvalid = 0; s_rvalid = 1; m1_rready = 1;
    @(negedge clk);
    clr();
    #1 check("t5_done", busy, 0);

    // reset asserted while waiting for B
    @(negedge clk);
    m1_awvalid = 1; m1_wvalid = 1; m1_bready = 1; s_awready = 1; s_wready = 1;
    @(negedge clk);
    @(negedge clk);
    #1 check("t6_in_wb", {busy, s_bready}, 2'b11);
    reset = 0;
    #1 check("t6_rst_busy", busy, 0);
    check("t6_rst_hs", hs, 0);
    @(negedge clk);
    s_bvalid = 1; m1_awvalid = 0; m1_wvalid = 0;
    #1 check("t6_late_b", m1_bvalid, 0);
    @(negedge clk);
    reset = 1; m0_arvalid = 1; m1_arvalid = 1;
    #1 check("t6_idle", busy, 0);
    check("t6_late_b2", m1_bvalid, 0);
    @(negedge clk);
    #1 check("t6_tie_grant", grant, TIE_FIRST);
    check("t6_tie_ar", s_arvalid, 1);
    clr();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
